unpack_stream: RTL and testbench
================================

Name: unpack_stream

Overview:
- Splits one wide concatenated word into its constituent elements and emits them one per handshake on a narrow valid/ready stream.
- It is the receive-side inverse of the team's concatenation/packing blocks: a packer builds `{e[N-1], ..., e[0]}` and this block takes that word apart again.
- It sits between a wide bus producer (for example a FIFO or register bank) and a narrow consumer such as a UART or byte lane.

Parameters:
- ELEM_W, 8, width of one element in bits (>=1).
- N_ELEM, 4, number of elements per packed input word (>=2).
- MSB_FIRST, 1, 1: emit `e[N_ELEM-1]` first; 0: emit `e[0]` first.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_arst_n  input  1  asynchronous active-low reset.
- i_in_valid  input  1  packed word offered.
- o_in_ready  output  1  block accepts the packed word this cycle.
- i_in_data  input  N_ELEM*ELEM_W  packed word; `e[k]` = bits `[k*ELEM_W +: ELEM_W]`.
- o_out_valid  output  1  element offered.
- i_out_ready  input  1  consumer accepts element this cycle.
- o_out_data  output  ELEM_W  current element.
- o_out_idx  output  $clog2(N_ELEM)  index k of current element.
- o_out_last  output  1  current element is the final one of its word.

Behaviour:
- Reset is asynchronous and active-low; all flops clear immediately on i_arst_n low and release synchronously to i_clk.
  - Reset values: o_out_valid=0, o_out_data=0, o_out_idx=0 (MSB_FIRST=0) or N_ELEM-1 (MSB_FIRST=1), o_out_last=0, state=EMPTY.
  - o_in_ready is 0 while in reset.
- Storage is one word register plus an element counter.
- FSM has two states:
  - EMPTY: o_out_valid=0, o_in_ready=1. When i_in_valid is high, capture i_in_data, load idx with the first index, go to DRAIN.
  - DRAIN: o_out_valid=1. o_out_data is the selected element of the held word.
    - On a handshake (o_out_valid & i_out_ready) where o_out_last=0: step idx (decrement if MSB_FIRST, else increment).
    - On a handshake where o_out_last=1: word finished; go to EMPTY unless a new word is accepted in the same cycle.
- o_in_ready = (state==EMPTY) | (state==DRAIN & o_out_last & i_out_ready).
  - This combinational path makes back-to-back words run with zero bubble: N_ELEM output beats per N_ELEM cycles.
  - If the last element handshakes and a new word is accepted in the same cycle, stay in DRAIN and load the new word and the first idx.
- Latency: the first element is valid on the cycle after input acceptance. There is no combinational path from i_in_data to o_out_*.
- o_out_last = (idx == last index), where last index is 0 if MSB_FIRST, else N_ELEM-1.
- While o_out_valid=1 and i_out_ready=0, o_out_data, o_out_idx and o_out_last hold stable. The AXI-style rule applies: valid is never withdrawn before its handshake.
- The idx counter never wraps past the last index. An out-of-range idx is unreachable.
- Reset mid-word discards the partial word. No element is re-emitted after reset.
- i_in_valid while in DRAIN, outside the last-element handshake cycle, is back-pressured with o_in_ready=0.

Optional Feature:
- Macro: UNPACK_STREAM_KEEP_EN.
- When defined:
  - An extra port i_in_keep (input, N_ELEM bits) is captured alongside i_in_data.
  - Elements with keep[k]=0 are skipped. idx jumps directly to the next set bit in emission order.
  - o_out_last is asserted on the final kept element.
  - A word with keep all-zero is accepted in EMPTY and consumed with no output beat; the block stays in EMPTY.
- When undefined: the port is absent, all elements are emitted, and the logic is identical to keep all-ones.

Decomposition:
- Package unpack_stream_pkg holds:
  - `typedef enum logic {EMPTY, DRAIN} state_t`;
  - a function returning the first/next index given MSB_FIRST;
  - a function returning the last index given MSB_FIRST.
- Sub-module unpack_stream_nextkeep exists only under UNPACK_STREAM_KEEP_EN. It is a combinational priority finder: (keep, current idx, MSB_FIRST) -> next kept idx plus a none-left flag.

Test Plan:
- Reset/idle: hold i_arst_n=0 for 3 cycles, then release with i_in_valid=0 -> o_out_valid=0, o_in_ready=1, no beats.
- Single word: defaults, i_in_data=32'hA1B2C3D4, i_out_ready=1 -> beats D4? no: MSB_FIRST=1 gives A1,B2,C3,D4. idx 3,2,1,0. Last only on D4. First beat one cycle after accept.
- MSB_FIRST=0 variant: same word -> beats D4,C3,B2,A1 with idx 0..3.
- Back-to-back: words 32'h01020304 and 32'h05060708 offered continuously with i_out_ready=1 -> 8 consecutive beats 01..08, no gap. o_in_ready=1 on the D4-equivalent (04) cycle.
- Back-pressure: i_out_ready low for 5 cycles on the second element -> o_out_data holds B2, o_in_ready=0. Sequence resumes intact when ready returns.
- Reset mid-word: assert i_arst_n=0 after 2 beats -> outputs clear immediately. A new word 32'hDEADBEEF after release emits DE,AD,BE,EF. Under UNPACK_STREAM_KEEP_EN, keep=4'b0101 on 32'hA1B2C3D4 emits B2 then D4 (last).

Source files
------------

// File: rtl/unpack_stream_pkg.sv
// Shared types and index helpers for the wide-word-to-element-stream unpacker.
// Optional keep-mask support is selected with the UNPACK_STREAM_KEEP_EN macro.
package unpack_stream_pkg;

    typedef enum logic {EMPTY, DRAIN} state_t;

    function automatic int unsigned first_idx(input int unsigned n_elem, input bit msb_first);
        return msb_first ? n_elem - 1 : 0;
    endfunction

    function automatic int unsigned step_idx(input int unsigned cur, input bit msb_first);
        return msb_first ? cur - 1 : cur + 1;
    endfunction

    function automatic int unsigned last_idx(input int unsigned n_elem, input bit msb_first);
        return msb_first ? 0 : n_elem - 1;
    endfunction

endpackage

// File: rtl/unpack_stream_nextkeep.sv
// Priority finder for the next kept element in emission order.
// Present only when UNPACK_STREAM_KEEP_EN is defined.
`ifdef UNPACK_STREAM_KEEP_EN
module unpack_stream_nextkeep #(
    parameter int N_ELEM    = 4,
    parameter int MSB_FIRST = 1,
    localparam int IDX_W    = $clog2(N_ELEM)
) (
    input  logic [N_ELEM-1:0] i_keep,
    input  logic [IDX_W-1:0]  i_cur,
    input  logic              i_incl,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_none
);

    // Walk positions in emission order; the first kept one at/after the cursor wins.
    always_comb begin
        int cur;
        int k;
        logic after;
        o_idx  = '0;
        o_none = 1'b1;
        cur    = int'(i_cur);
        for (int s = 0; s < N_ELEM; s++) begin
            k     = (MSB_FIRST != 0) ? (N_ELEM - 1 - s) : s;
            after = (MSB_FIRST != 0) ? (k < cur) : (k > cur);
            if (i_incl && (k == cur)) begin
                after = 1'b1;
            end
            if (o_none && after && i_keep[k]) begin
                o_idx  = IDX_W'(k);
                o_none = 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/unpack_stream.sv
// Splits a packed word {e[N-1],...,e[0]} into a one-element-per-beat valid/ready stream.
// Define UNPACK_STREAM_KEEP_EN to add i_in_keep and skip unkept elements.
module unpack_stream
    import unpack_stream_pkg::*;
#(
    parameter int ELEM_W    = 8,
    parameter int N_ELEM    = 4,
    parameter int MSB_FIRST = 1,
    localparam int IDX_W    = $clog2(N_ELEM)
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [N_ELEM*ELEM_W-1:0] i_in_data,
`ifdef UNPACK_STREAM_KEEP_EN
    input  logic [N_ELEM-1:0]        i_in_keep,
`endif
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [ELEM_W-1:0]        o_out_data,
    output logic [IDX_W-1:0]         o_out_idx,
    output logic                     o_out_last
);

    localparam logic [IDX_W-1:0] FIRST = IDX_W'(first_idx(N_ELEM, MSB_FIRST != 0));
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(last_idx(N_ELEM, MSB_FIRST != 0));

    state_t                         state_q, state_d;
    logic [N_ELEM-1:0][ELEM_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]               idx_q, idx_d;

    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] idx_first;
    logic             first_none;
    logic             last_elem;
    logic             hs;
    logic             acc;

`ifdef UNPACK_STREAM_KEEP_EN
    logic [N_ELEM-1:0] keep_q, keep_d;
    logic              step_none;

    unpack_stream_nextkeep #(.N_ELEM(N_ELEM), .MSB_FIRST(MSB_FIRST)) u_step (
        .i_keep (keep_q),
        .i_cur  (idx_q),
        .i_incl (1'b0),
        .o_idx  (idx_next),
        .o_none (step_none)
    );

    unpack_stream_nextkeep #(.N_ELEM(N_ELEM), .MSB_FIRST(MSB_FIRST)) u_first (
        .i_keep (i_in_keep),
        .i_cur  (FIRST),
        .i_incl (1'b1),
        .o_idx  (idx_first),
        .o_none (first_none)
    );

    // Last means no kept element remains after the current one.
    assign last_elem = step_none;
`else
    assign idx_next   = IDX_W'(step_idx(32'(idx_q), MSB_FIRST != 0));
    assign idx_first  = FIRST;
    assign first_none = 1'b0;
    assign last_elem  = (idx_q == LAST);
`endif

    assign o_out_valid = (state_q == DRAIN);
    assign o_out_data  = word_q[idx_q];
    assign o_out_idx   = idx_q;
    assign o_out_last  = o_out_valid & last_elem;
    // Accepting during the final beat gives zero-bubble back-to-back words.
    assign o_in_ready  = i_arst_n & ((state_q == EMPTY) | (o_out_last & i_out_ready));

    assign hs  = o_out_valid & i_out_ready;
    assign acc = i_in_valid & o_in_ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
`ifdef UNPACK_STREAM_KEEP_EN
        keep_d  = keep_q;
`endif
        if (acc) begin
            word_d  = i_in_data;
            idx_d   = idx_first;
            state_d = first_none ? EMPTY : DRAIN;
`ifdef UNPACK_STREAM_KEEP_EN
            keep_d  = i_in_keep;
`endif
        end else if (hs) begin
            if (o_out_last) begin
                state_d = EMPTY;
            end else begin
                idx_d = idx_next;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= EMPTY;
            word_q  <= '0;
            idx_q   <= FIRST;
`ifdef UNPACK_STREAM_KEEP_EN
            keep_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
`ifdef UNPACK_STREAM_KEEP_EN
            keep_q  <= keep_d;
`endif
        end
    end

endmodule

// File: tb/tb_unpack_stream.sv
// Bench for unpack_stream: an MSB-first and an LSB-first instance share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_unpack_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic [3:0]  in_keep;

    logic       a_in_ready, a_valid, a_last;
    logic [7:0] a_data;
    logic [1:0] a_idx;
    logic       b_in_ready, b_valid, b_last;
    logic [7:0] b_data;
    logic [1:0] b_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    unpack_stream #(.ELEM_W(8), .N_ELEM(4), .MSB_FIRST(1)) dut_a (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (a_in_ready),
        .i_in_data   (in_data),
`ifdef UNPACK_STREAM_KEEP_EN
        .i_in_keep   (in_keep),
`endif
        .o_out_valid (a_valid),
        .i_out_ready (out_ready),
        .o_out_data  (a_data),
        .o_out_idx   (a_idx),
        .o_out_last  (a_last)
    );

    unpack_stream #(.ELEM_W(8), .N_ELEM(4), .MSB_FIRST(0)) dut_b (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (b_in_ready),
        .i_in_data   (in_data),
`ifdef UNPACK_STREAM_KEEP_EN
        .i_in_keep   (in_keep),
`endif
        .o_out_valid (b_valid),
        .i_out_ready (out_ready),
        .o_out_data  (b_data),
        .o_out_idx   (b_idx),
        .o_out_last  (b_last)
    );

    // Reference model: each accepted word becomes a queue of (element, index) beats.
    typedef struct packed {
        logic [7:0] d;
        logic [1:0] k;
    } beat_t;

    beat_t       qa[$];
    beat_t       qb[$];
    int          n_acc = 0;
    int          cyc   = 0;
    logic        rdy_m;
    logic [7:0]  log_a[$];
    logic [7:0]  log_b[$];
    int          log_cyc[$];
    logic [31:0] wq[$];
    logic [3:0]  kq[$];

    function automatic logic exp_rdy();
        return rst_n && (qa.size() == 0 || (qa.size() == 1 && out_ready));
    endfunction

    function automatic logic [12:0] exp_vec(input bit use_b);
        beat_t f;
        int    n;
        n = use_b ? qb.size() : qa.size();
        if (n == 0) return {1'b0, 8'h00, 2'd0, 1'b0, exp_rdy()};
        f = use_b ? qb[0] : qa[0];
        return {1'b1, f.d, f.k, (n == 1), exp_rdy()};
    endfunction

    function automatic logic [12:0] obs_vec(input bit use_b);
        if (use_b) return {b_valid, b_valid ? b_data : 8'h00, b_valid ? b_idx : 2'd0, b_last, b_in_ready};
        return {a_valid, a_valid ? a_data : 8'h00, a_valid ? a_idx : 2'd0, a_last, a_in_ready};
    endfunction

    function automatic logic [71:0] pack_log(input bit use_b);
        logic [63:0] r;
        int          n;
        r = '0;
        n = use_b ? log_b.size() : log_a.size();
        for (int i = 0; i < n && i < 8; i++) r = {r[55:0], use_b ? log_b[i] : log_a[i]};
        return {8'(n), r};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            cyc++;
            if (a_valid && out_ready) begin
                log_a.push_back(a_data);
                log_cyc.push_back(cyc);
            end
            if (b_valid && out_ready) log_b.push_back(b_data);
            rdy_m = exp_rdy();
            if (qa.size() > 0 && out_ready) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (in_valid && rdy_m) begin
                n_acc++;
                for (int k = 3; k >= 0; k--)
                    if (in_keep[k]) qa.push_back(beat_t'({in_data[k*8 +: 8], 2'(k)}));
                for (int k = 0; k < 4; k++)
                    if (in_keep[k]) qb.push_back(beat_t'({in_data[k*8 +: 8], 2'(k)}));
            end
        end
    end

    // Offers wq[] in order, advancing as the model sees each word accepted.
    task automatic set_offer(input int acc0, input logic rdy);
        int wi;
        wi        = n_acc - acc0;
        in_valid  = (wi < wq.size());
        in_data   = in_valid ? wq[wi] : 32'h0;
        in_keep   = in_valid ? kq[wi] : 4'hF;
`ifndef UNPACK_STREAM_KEEP_EN
        in_keep   = 4'hF;
`endif
        out_ready = rdy;
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_b.delete();
        log_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_keep = 4'hF;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_valid, a_data, a_idx, a_last, a_in_ready} !== {1'b0, 8'h00, 2'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a got=%h want=%h", {a_valid, a_data, a_idx, a_last, a_in_ready}, {1'b0, 8'h00, 2'd3, 1'b0, 1'b0});
        end
        n_checks++;
        if ({b_valid, b_data, b_idx, b_last, b_in_ready} !== {1'b0, 8'h00, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b got=%h want=%h", {b_valid, b_data, b_idx, b_last, b_in_ready}, {1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
        end
        rst_n = 1'b1;
        clear_logs();
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({a_valid, a_in_ready, b_valid, b_in_ready} !== 4'b0101) begin
                n_fail++;
                $display("FAIL idle got=%b want=0101", {a_valid, a_in_ready, b_valid, b_in_ready});
            end
        end
        n_checks++;
        if (log_a.size() + log_b.size() != 0) begin
            n_fail++;
            $display("FAIL idle_beats got=%0d want=0", log_a.size() + log_b.size());
        end
    endtask

    task automatic test_single();
        int acc0;
        acc0 = n_acc;
        wq = '{32'hA1B2C3D4};
        kq = '{4'hF};
        clear_logs();
        for (int c = 0; c < 8; c++) begin
            set_offer(acc0, 1'b1);
            @(negedge clk);
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++; $display("FAIL single_a c=%0d got=%h want=%h", c, obs_vec(0), exp_vec(0));
            end
            n_checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                n_fail++; $display("FAIL single_b c=%0d got=%h want=%h", c, obs_vec(1), exp_vec(1));
            end
        end
        n_checks++;
        if (pack_log(0) !== {8'd4, 64'hA1B2C3D4}) begin
            n_fail++; $display("FAIL single_seq_a got=%h want=%h", pack_log(0), {8'd4, 64'hA1B2C3D4});
        end
        n_checks++;
        if (pack_log(1) !== {8'd4, 64'hD4C3B2A1}) begin
            n_fail++; $display("FAIL single_seq_b got=%h want=%h", pack_log(1), {8'd4, 64'hD4C3B2A1});
        end
    endtask

    task automatic test_back_to_back();
        int acc0;
        acc0 = n_acc;
        wq = '{32'h01020304, 32'h05060708};
        kq = '{4'hF, 4'hF};
        clear_logs();
        for (int c = 0; c < 12; c++) begin
            set_offer(acc0, 1'b1);
            @(negedge clk);
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++; $display("FAIL b2b_a c=%0d got=%h want=%h", c, obs_vec(0), exp_vec(0));
            end
            n_checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                n_fail++; $display("FAIL b2b_b c=%0d got=%h want=%h", c, obs_vec(1), exp_vec(1));
            end
        end
        n_checks++;
        if (pack_log(0) !== {8'd8, 64'h0102030405060708}) begin
            n_fail++; $display("FAIL b2b_seq_a got=%h want=%h", pack_log(0), {8'd8, 64'h0102030405060708});
        end
        n_checks++;
        if (pack_log(1) !== {8'd8, 64'h0403020108070605}) begin
            n_fail++; $display("FAIL b2b_seq_b got=%h want=%h", pack_log(1), {8'd8, 64'h0403020108070605});
        end
        n_checks++;
        if (log_cyc.size() != 8 || log_cyc[log_cyc.size()-1] - log_cyc[0] != 7) begin
            n_fail++; $display("FAIL b2b_gap beats=%0d want=8 contiguous", log_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        int acc0;
        acc0 = n_acc;
        wq = '{32'hA1B2C3D4, 32'h11223344};
        kq = '{4'hF, 4'hF};
        clear_logs();
        for (int c = 0; c < 16; c++) begin
            set_offer(acc0, !(c >= 2 && c < 7));
            @(negedge clk);
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++; $display("FAIL bp_a c=%0d got=%h want=%h", c, obs_vec(0), exp_vec(0));
            end
            n_checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                n_fail++; $display("FAIL bp_b c=%0d got=%h want=%h", c, obs_vec(1), exp_vec(1));
            end
            if (c >= 2 && c < 7) begin
                n_checks++;
                if ({a_valid, a_data, a_in_ready} !== {1'b1, 8'hB2, 1'b0}) begin
                    n_fail++; $display("FAIL bp_hold c=%0d got=%h want=%h", c, {a_valid, a_data, a_in_ready}, {1'b1, 8'hB2, 1'b0});
                end
            end
        end
        n_checks++;
        if (pack_log(0) !== {8'd8, 64'hA1B2C3D411223344}) begin
            n_fail++; $display("FAIL bp_seq_a got=%h want=%h", pack_log(0), {8'd8, 64'hA1B2C3D411223344});
        end
        n_checks++;
        if (pack_log(1) !== {8'd8, 64'hD4C3B2A144332211}) begin
            n_fail++; $display("FAIL bp_seq_b got=%h want=%h", pack_log(1), {8'd8, 64'hD4C3B2A144332211});
        end
    endtask

    task automatic test_reset_mid();
        int acc0;
        acc0 = n_acc;
        wq = '{32'hA1B2C3D4};
        kq = '{4'hF};
        clear_logs();
        for (int c = 0; c < 10 && log_a.size() < 2; c++) begin
            set_offer(acc0, 1'b1);
            @(negedge clk);
        end
        n_checks++;
        if (log_a.size() != 2) begin
            n_fail++; $display("FAIL rmid_pre beats=%0d want=2", log_a.size());
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_valid, a_data, a_idx, a_last, a_in_ready, b_valid} !== {1'b0, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_async got=%h want=%h", {a_valid, a_data, a_idx, a_last, a_in_ready, b_valid}, {1'b0, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acc0 = n_acc;
        wq = '{32'hDEADBEEF};
        clear_logs();
        for (int c = 0; c < 8; c++) begin
            set_offer(acc0, 1'b1);
            @(negedge clk);
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++; $display("FAIL rmid_a c=%0d got=%h want=%h", c, obs_vec(0), exp_vec(0));
            end
        end
        n_checks++;
        if (pack_log(0) !== {8'd4, 64'hDEADBEEF}) begin
            n_fail++; $display("FAIL rmid_seq_a got=%h want=%h", pack_log(0), {8'd4, 64'hDEADBEEF});
        end
        n_checks++;
        if (pack_log(1) !== {8'd4, 64'hEFBEADDE}) begin
            n_fail++; $display("FAIL rmid_seq_b got=%h want=%h", pack_log(1), {8'd4, 64'hEFBEADDE});
        end
    endtask

`ifdef UNPACK_STREAM_KEEP_EN
    task automatic test_keep();
        int acc0;
        acc0 = n_acc;
        wq = '{32'hA1B2C3D4, 32'h55667788, 32'h99AABBCC};
        kq = '{4'b0101, 4'b0000, 4'b1000};
        clear_logs();
        for (int c = 0; c < 10; c++) begin
            set_offer(acc0, 1'b1);
            @(negedge clk);
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++; $display("FAIL keep_a c=%0d got=%h want=%h", c, obs_vec(0), exp_vec(0));
            end
            n_checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                n_fail++; $display("FAIL keep_b c=%0d got=%h want=%h", c, obs_vec(1), exp_vec(1));
            end
        end
        n_checks++;
        if (pack_log(0) !== {8'd3, 64'hB2D499}) begin
            n_fail++; $display("FAIL keep_seq_a got=%h want=%h", pack_log(0), {8'd3, 64'hB2D499});
        end
        n_checks++;
        if (pack_log(1) !== {8'd3, 64'hD4B299}) begin
            n_fail++; $display("FAIL keep_seq_b got=%h want=%h", pack_log(1), {8'd3, 64'hD4B299});
        end
    endtask
`endif

    task automatic test_random();
        int acc0;
        acc0 = n_acc;
        wq.delete();
        kq.delete();
        for (int i = 0; i < 120; i++) begin
            wq.push_back($urandom);
            kq.push_back(4'($urandom_range(0, 15)));
        end
        for (int c = 0; c < 400; c++) begin
            set_offer(acc0, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++; $display("FAIL rand_a c=%0d got=%h want=%h", c, obs_vec(0), exp_vec(0));
            end
            n_checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                n_fail++; $display("FAIL rand_b c=%0d got=%h want=%h", c, obs_vec(1), exp_vec(1));
            end
        end
        n_checks++;
        if (n_acc - acc0 < 20) begin
            n_fail++; $display("FAIL rand_progress got=%0d want>=20", n_acc - acc0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef UNPACK_STREAM_KEEP_EN
        test_keep();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
